// File: rtl/sound_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
// Shared types and constants for the sound arbiter slice.
//   sound_state_e : arbiter FSM states (IDLE, START, PLAYING, ABORT)
//   SOUND_WORD_W  : width of the duration / half-period words
// No ports (package).
// -----------------------------------------------------------------------------
package sound_pkg;

  localparam int SOUND_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    PLAYING = 2'd2,
    ABORT   = 2'd3
  } sound_state_e;

endpackage : sound_pkg

// File: rtl/sound_arbiter_if.sv
// -----------------------------------------------------------------------------
// sound_arbiter_if
// Bundles the requester-side and generator-side signals of the sound arbiter.
// Parameter:
//   REQUESTERS : number of requester channels (index 0 = highest priority)
// Signals:
//   Request_i          : level request per channel
//   Duration_ms_i      : packed per-channel durations, channel k at [16k+15:16k]
//   HalfPeriod_us_i    : packed per-channel half periods, same packing
//   Grant_o            : one-hot owner of the generator
//   Done_o             : one-cycle completion/abort pulse per channel
//   GenStart_o         : start pulse to the generator
//   GenFinish_o        : abort pulse to the generator
//   GenDuration_ms_o   : latched duration
//   GenHalfPeriod_us_o : latched half period
//   GenBusy_i          : generator busy
//   GenDone_i          : generator one-cycle done pulse
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters + generator)
// -----------------------------------------------------------------------------
interface sound_arbiter_if
  import sound_pkg::*;
#(
  parameter int REQUESTERS = 4
) ();

  logic [REQUESTERS-1:0]              Request_i;
  logic [SOUND_WORD_W*REQUESTERS-1:0] Duration_ms_i;
  logic [SOUND_WORD_W*REQUESTERS-1:0] HalfPeriod_us_i;
  logic [REQUESTERS-1:0]              Grant_o;
  logic [REQUESTERS-1:0]              Done_o;
  logic                               GenStart_o;
  logic                               GenFinish_o;
  logic [SOUND_WORD_W-1:0]            GenDuration_ms_o;
  logic [SOUND_WORD_W-1:0]            GenHalfPeriod_us_o;
  logic                               GenBusy_i;
  logic                               GenDone_i;

  modport slave (
    input  Request_i, Duration_ms_i, HalfPeriod_us_i, GenBusy_i, GenDone_i,
    output Grant_o, Done_o, GenStart_o, GenFinish_o,
           GenDuration_ms_o, GenHalfPeriod_us_o
  );

  modport master (
    output Request_i, Duration_ms_i, HalfPeriod_us_i, GenBusy_i, GenDone_i,
    input  Grant_o, Done_o, GenStart_o, GenFinish_o,
           GenDuration_ms_o, GenHalfPeriod_us_o
  );

endinterface : sound_arbiter_if

// File: rtl/sound_arbiter_priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
// Lowest-index-wins one-hot priority encoder (purely combinational).
// Parameter:
//   WIDTH : number of request bits
// Ports:
//   req    in  WIDTH : request vector
//   onehot out WIDTH : one-hot of the lowest set bit of req (0 if none)
//   valid  out 1     : any bit of req set
// -----------------------------------------------------------------------------
module priority_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] onehot,
  output logic             valid
);

  // lower_any[i] is set when any request below bit i is active.
  logic [WIDTH:0] lower_any;

  assign lower_any[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign onehot[gi]      = req[gi] & ~lower_any[gi];
    assign lower_any[gi+1] = lower_any[gi] | req[gi];
  end

  assign valid = lower_any[WIDTH];

endmodule : priority_encoder

// File: rtl/sound_arbiter.sv
// -----------------------------------------------------------------------------
// sound_arbiter
// Fixed-priority arbiter sharing one SoundGenerator among REQUESTERS tone
// requesters. Grants the lowest requesting index, latches its duration and
// half period, pulses the generator start and returns a per-channel done
// pulse when the tone ends.
// Parameter:
//   REQUESTERS : number of channels (index 0 = highest priority)
// Ports:
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high reset
//   bus   : sound_arbiter_if.slave (requester + generator signals)
// Optional feature:
//   SOUND_ARBITER_PREEMPT_EN : when defined, a request from a higher-priority
//   channel aborts the playing tone; the preempted channel gets Done_o when
//   the abort completes so it can retry.
// -----------------------------------------------------------------------------
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int REQUESTERS = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  sound_arbiter_if.slave  bus
);

  typedef logic [REQUESTERS-1:0] req_vec_t;
  typedef logic [SOUND_WORD_W-1:0] word_t;

  sound_state_e state_reg, state_next;
  req_vec_t     grant_reg, grant_next;
  req_vec_t     done_reg, done_next;
  logic         gen_start_reg, gen_start_next;
  logic         gen_finish_reg, gen_finish_next;
  word_t        dur_reg, dur_next;
  word_t        hp_reg, hp_next;
  // Remembers that the current abort came from a preemption, which is the
  // only abort that reports Done_o on exit.
  logic         preempted_reg, preempted_next;

  req_vec_t sel_onehot;
  logic     sel_valid;
  word_t    sel_dur, sel_hp;
  logic     own_req;
  logic     preempt_hit;

  // ---------------------------------------------------------------------------
  // Arbitration: lowest requesting index
  // ---------------------------------------------------------------------------
  priority_encoder #(
    .WIDTH (REQUESTERS)
  ) u_arb_enc (
    .req    (bus.Request_i),
    .onehot (sel_onehot),
    .valid  (sel_valid)
  );

  // One-hot mux of the winning channel's parameters.
  word_t dur_masked [REQUESTERS];
  word_t hp_masked  [REQUESTERS];

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_mask
    assign dur_masked[gi] = sel_onehot[gi] ?
                            bus.Duration_ms_i[SOUND_WORD_W*gi +: SOUND_WORD_W] : '0;
    assign hp_masked[gi]  = sel_onehot[gi] ?
                            bus.HalfPeriod_us_i[SOUND_WORD_W*gi +: SOUND_WORD_W] : '0;
  end

  always_comb begin
    sel_dur = '0;
    sel_hp  = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      sel_dur = sel_dur | dur_masked[i];
      sel_hp  = sel_hp  | hp_masked[i];
    end
  end

  // The granted channel is still asking for its tone.
  assign own_req = |(bus.Request_i & grant_reg);

  // ---------------------------------------------------------------------------
  // Preemption check: any request strictly below the granted index
  // ---------------------------------------------------------------------------
`ifdef SOUND_ARBITER_PREEMPT_EN
  req_vec_t higher_req, higher_onehot;
  logic     higher_valid;

  // grant_reg is one-hot while PLAYING, so grant-1 masks all lower indices.
  assign higher_req = bus.Request_i & (grant_reg - req_vec_t'(1));

  priority_encoder #(
    .WIDTH (REQUESTERS)
  ) u_preempt_enc (
    .req    (higher_req),
    .onehot (higher_onehot),
    .valid  (higher_valid)
  );

  assign preempt_hit = higher_valid && (higher_onehot != '0);
`else
  assign preempt_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      done_reg       <= '0;
      gen_start_reg  <= 1'b0;
      gen_finish_reg <= 1'b0;
      dur_reg        <= '0;
      hp_reg         <= '0;
      preempted_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      done_reg       <= done_next;
      gen_start_reg  <= gen_start_next;
      gen_finish_reg <= gen_finish_next;
      dur_reg        <= dur_next;
      hp_reg         <= hp_next;
      preempted_reg  <= preempted_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state / outputs. Pulses (done, start, finish) default to 0 so each
  // is high for exactly the one cycle after the edge that requested it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    done_next       = '0;
    gen_start_next  = 1'b0;
    gen_finish_next = 1'b0;
    dur_next        = dur_reg;
    hp_next         = hp_reg;
    preempted_next  = preempted_reg;

    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          if (sel_dur == '0) begin
            // Nothing to play: acknowledge immediately, generator untouched.
            done_next = sel_onehot;
          end else begin
            dur_next       = sel_dur;
            hp_next        = sel_hp;
            grant_next     = sel_onehot;
            gen_start_next = 1'b1;
            preempted_next = 1'b0;
            state_next     = START;
          end
        end
      end

      START: begin
        state_next = PLAYING;
      end

      PLAYING: begin
        // Done has precedence over a drop; a drop has precedence over
        // preemption (a dropped requester expects no Done_o).
        if (bus.GenDone_i) begin
          done_next  = grant_reg;
          grant_next = '0;
          state_next = IDLE;
        end else if (!own_req) begin
          gen_finish_next = 1'b1;
          preempted_next  = 1'b0;
          state_next      = ABORT;
        end else if (preempt_hit) begin
          gen_finish_next = 1'b1;
          preempted_next  = 1'b1;
          state_next      = ABORT;
        end
      end

      ABORT: begin
        if (!bus.GenBusy_i) begin
          if (preempted_reg) begin
            done_next = grant_reg;
          end
          grant_next     = '0;
          preempted_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.Grant_o            = grant_reg;
  assign bus.Done_o             = done_reg;
  assign bus.GenStart_o         = gen_start_reg;
  assign bus.GenFinish_o        = gen_finish_reg;
  assign bus.GenDuration_ms_o   = dur_reg;
  assign bus.GenHalfPeriod_us_o = hp_reg;

endmodule : sound_arbiter

// File: tb/tb_sound_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sound_arbiter
// Directed self-checking bench for sound_arbiter (REQUESTERS = 4). The
// generator is modelled by driving GenBusy_i / GenDone_i directly.
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, i.e. they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_sound_arbiter;

  logic Clock = 1'b0;
  logic Reset;

  int total = 0;
  int bad   = 0;

  sound_arbiter_if #(.REQUESTERS(4)) bus ();

  sound_arbiter #(
    .REQUESTERS (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [15:0] dur, input logic [15:0] hp);
    bus.Duration_ms_i[16*k +: 16]   = dur;
    bus.HalfPeriod_us_i[16*k +: 16] = hp;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  32'(bus.Grant_o), 32'h0);
    chk({tag, "_done"},   32'(bus.Done_o), 32'h0);
    chk({tag, "_start"},  32'(bus.GenStart_o), 32'h0);
    chk({tag, "_finish"}, 32'(bus.GenFinish_o), 32'h0);
    chk({tag, "_dur"},    32'(bus.GenDuration_ms_o), 32'h0);
    chk({tag, "_hp"},     32'(bus.GenHalfPeriod_us_o), 32'h0);
  endtask

  initial begin
    Reset               = 1'b1;
    bus.Request_i       = '0;
    bus.Duration_ms_i   = '0;
    bus.HalfPeriod_us_i = '0;
    bus.GenBusy_i       = 1'b0;
    bus.GenDone_i       = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    $display("txn reset");
    chk_all_zero("reset");
    Reset = 1'b0;

    // ---------------- single request: ch2 100/500 ----------------
    $display("txn single ch2 100ms/500us");
    set_ch(2, 16'd100, 16'd500);
    bus.Request_i = 4'b0100;
    tick();
    chk("single_grant", 32'(bus.Grant_o), 32'h4);
    chk("single_start", 32'(bus.GenStart_o), 32'h1);
    chk("single_dur",   32'(bus.GenDuration_ms_o), 32'd100);
    chk("single_hp",    32'(bus.GenHalfPeriod_us_o), 32'd500);
    bus.GenBusy_i = 1'b1;
    tick();
    chk("single_start_once", 32'(bus.GenStart_o), 32'h0);
    chk("single_grant_hold", 32'(bus.Grant_o), 32'h4);
    tick();
    bus.GenDone_i = 1'b1;
    tick();
    bus.GenDone_i = 1'b0;
    bus.GenBusy_i = 1'b0;
    chk("single_done",      32'(bus.Done_o), 32'h4);
    chk("single_grant_clr", 32'(bus.Grant_o), 32'h0);
    bus.Request_i = 4'b0000;
    tick();
    chk("single_done_once", 32'(bus.Done_o), 32'h0);

    // GenDone_i while IDLE must be ignored
    $display("txn stray done in idle");
    bus.GenDone_i = 1'b1;
    tick();
    bus.GenDone_i = 1'b0;
    chk("stray_done", 32'(bus.Done_o), 32'h0);
    chk("stray_grant", 32'(bus.Grant_o), 32'h0);

    // ---------------- simultaneous ch1 + ch3 ----------------
    $display("txn simultaneous ch1 200/300 + ch3 400/600");
    set_ch(1, 16'd200, 16'd300);
    set_ch(3, 16'd400, 16'd600);
    bus.Request_i = 4'b1010;
    tick();
    chk("sim_grant1", 32'(bus.Grant_o), 32'h2);
    chk("sim_dur1",   32'(bus.GenDuration_ms_o), 32'd200);
    chk("sim_hp1",    32'(bus.GenHalfPeriod_us_o), 32'd300);
    bus.GenBusy_i = 1'b1;
    set_ch(1, 16'd999, 16'd888);   // must not disturb the latched values
    tick();
    tick();
    chk("sim_dur1_stable", 32'(bus.GenDuration_ms_o), 32'd200);
    chk("sim_hp1_stable",  32'(bus.GenHalfPeriod_us_o), 32'd300);
    bus.GenDone_i = 1'b1;
    tick();
    bus.GenDone_i = 1'b0;
    bus.GenBusy_i = 1'b0;
    chk("sim_done1", 32'(bus.Done_o), 32'h2);
    chk("sim_gap",   32'(bus.Grant_o), 32'h0);
    bus.Request_i = 4'b1000;
    tick();
    chk("sim_grant3", 32'(bus.Grant_o), 32'h8);
    chk("sim_start3", 32'(bus.GenStart_o), 32'h1);
    chk("sim_dur3",   32'(bus.GenDuration_ms_o), 32'd400);
    chk("sim_hp3",    32'(bus.GenHalfPeriod_us_o), 32'd600);
    bus.GenBusy_i = 1'b1;
    tick();
    // done and request drop in the same cycle: done wins
    bus.GenDone_i = 1'b1;
    bus.Request_i = 4'b0000;
    tick();
    bus.GenDone_i = 1'b0;
    bus.GenBusy_i = 1'b0;
    chk("sim_done3",     32'(bus.Done_o), 32'h8);
    chk("sim_no_finish", 32'(bus.GenFinish_o), 32'h0);
    chk("sim_grant_clr", 32'(bus.Grant_o), 32'h0);
    tick();
    chk("sim_done3_once", 32'(bus.Done_o), 32'h0);

    // ---------------- zero duration on ch0 ----------------
    $display("txn zero duration ch0");
    set_ch(0, 16'd0, 16'd123);
    bus.Request_i = 4'b0001;
    tick();
    chk("zero_done",  32'(bus.Done_o), 32'h1);
    chk("zero_grant", 32'(bus.Grant_o), 32'h0);
    chk("zero_start", 32'(bus.GenStart_o), 32'h0);
    bus.Request_i = 4'b0000;
    tick();
    chk("zero_done_once", 32'(bus.Done_o), 32'h0);
    chk("zero_start2",    32'(bus.GenStart_o), 32'h0);

    // ---------------- requester drop on ch3 ----------------
    $display("txn drop ch3 500/250");
    set_ch(3, 16'd500, 16'd250);
    bus.Request_i = 4'b1000;
    tick();
    chk("drop_grant", 32'(bus.Grant_o), 32'h8);
    bus.GenBusy_i = 1'b1;
    tick();
    tick();
    bus.Request_i = 4'b0000;
    tick();
    chk("drop_finish", 32'(bus.GenFinish_o), 32'h1);
    chk("drop_grant_hold0", 32'(bus.Grant_o), 32'h8);
    chk("drop_no_done0", 32'(bus.Done_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drop_finish_once%0d", i), 32'(bus.GenFinish_o), 32'h0);
      chk($sformatf("drop_grant_hold%0d", i+1), 32'(bus.Grant_o), 32'h8);
      chk($sformatf("drop_no_done%0d", i+1), 32'(bus.Done_o), 32'h0);
    end
    bus.GenBusy_i = 1'b0;
    tick();
    chk("drop_grant_clr", 32'(bus.Grant_o), 32'h0);
    chk("drop_no_done_exit", 32'(bus.Done_o), 32'h0);
    tick();
    chk("drop_no_done_after", 32'(bus.Done_o), 32'h0);

    // ---------------- higher priority request during ch2 tone ----------------
    $display("txn priority request ch0 during ch2");
    set_ch(2, 16'd100, 16'd500);
    set_ch(0, 16'd50, 16'd70);
    bus.Request_i = 4'b0100;
    tick();
    chk("pre_grant2", 32'(bus.Grant_o), 32'h4);
    bus.GenBusy_i = 1'b1;
    tick();
    bus.Request_i = 4'b0101;
    tick();
`ifdef SOUND_ARBITER_PREEMPT_EN
    chk("pre_finish", 32'(bus.GenFinish_o), 32'h1);
    chk("pre_grant_hold", 32'(bus.Grant_o), 32'h4);
    bus.GenBusy_i = 1'b0;
    tick();
    chk("pre_done2", 32'(bus.Done_o), 32'h4);
    chk("pre_grant_clr", 32'(bus.Grant_o), 32'h0);
    bus.Request_i = 4'b0001;
    tick();
`else
    chk("pre_no_finish", 32'(bus.GenFinish_o), 32'h0);
    chk("pre_grant_hold", 32'(bus.Grant_o), 32'h4);
    tick();
    chk("pre_grant_hold2", 32'(bus.Grant_o), 32'h4);
    bus.GenDone_i = 1'b1;
    tick();
    bus.GenDone_i = 1'b0;
    bus.GenBusy_i = 1'b0;
    chk("pre_done2", 32'(bus.Done_o), 32'h4);
    chk("pre_grant_clr", 32'(bus.Grant_o), 32'h0);
    bus.Request_i = 4'b0001;
    tick();
`endif
    chk("pre_grant0", 32'(bus.Grant_o), 32'h1);
    chk("pre_start0", 32'(bus.GenStart_o), 32'h1);
    chk("pre_dur0",   32'(bus.GenDuration_ms_o), 32'd50);
    bus.GenBusy_i = 1'b1;
    tick();
    bus.GenDone_i = 1'b1;
    tick();
    bus.GenDone_i = 1'b0;
    bus.GenBusy_i = 1'b0;
    chk("pre_done0", 32'(bus.Done_o), 32'h1);
    bus.Request_i = 4'b0000;
    tick();

    // ---------------- reset mid-PLAYING ----------------
    $display("txn reset mid-tone ch1 200/300");
    set_ch(1, 16'd200, 16'd300);
    bus.Request_i = 4'b0010;
    tick();
    bus.GenBusy_i = 1'b1;
    tick();
    chk("rst_pre_grant", 32'(bus.Grant_o), 32'h2);
    Reset = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    Reset         = 1'b0;
    bus.GenBusy_i = 1'b0;
    bus.Request_i = 4'b0000;
    tick();
    chk("rst_idle_grant", 32'(bus.Grant_o), 32'h0);
    bus.Request_i = 4'b0010;
    tick();
    chk("rst_rearb_grant", 32'(bus.Grant_o), 32'h2);
    chk("rst_rearb_start", 32'(bus.GenStart_o), 32'h1);
    bus.Request_i = 4'b0000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sound_arbiter
